// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Signal bundle between the raster timing generator, the frame source and
//   the video output pins.
//
//   Request/response protocol (one rule, no back-pressure):
//     pixel_req high in cycle n names the pixel (hcount_req, vcount_req).
//     The source must present that pixel on rgb_in in cycle n+1. There is
//     no ready signal, so every request is accepted.
//
//   Signals
//     pll_locked   PLL lock, asynchronous to the pixel clock
//     pixel_req    request pixel at (hcount_req, vcount_req)
//     hcount_req   x of requested pixel (9 bits)
//     vcount_req   y of requested pixel (8 bits)
//     rgb_in       source pixel, valid the cycle after pixel_req
//     rgb_out      registered pixel, aligned with de, zero when de=0
//     de           active video
//     hsync        active-high horizontal sync
//     vsync        active-high vertical sync
//     frame_start  one-cycle pulse on the first de cycle of a frame
//     running      high while the generator is in RUN
//     state_dbg    current FSM state (0 WAIT_LOCK, 1 SETTLE, 2 RUN)
//
//   Modports: master = the timing generator, slave = source/sink side.
interface video_timing_gen_if;
  logic        pll_locked;
  logic        pixel_req;
  logic [8:0]  hcount_req;
  logic [7:0]  vcount_req;
  logic [23:0] rgb_in;
  logic [23:0] rgb_out;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        running;
  logic [1:0]  state_dbg;

  modport master (
    input  pll_locked, rgb_in,
    output pixel_req, hcount_req, vcount_req, rgb_out,
    output de, hsync, vsync, frame_start, running, state_dbg
  );

  modport slave (
    output pll_locked, rgb_in,
    input  pixel_req, hcount_req, vcount_req, rgb_out,
    input  de, hsync, vsync, frame_start, running, state_dbg
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for the 6 MHz pixel clock. Holds the video
//   pipeline idle until the PLL has been continuously locked for LOCK_WAIT
//   cycles, then runs the h/v raster counters, issues one-cycle-ahead pixel
//   requests to the frame source and emits de/hsync/vsync/frame_start and
//   the registered pixel, all aligned two cycles after the request.
//
//   Ports
//     clk   pixel clock
//     rst   synchronous, active-high reset
//     vif   video_timing_gen_if.master (see the interface for the signal list)
//
//   Build option
//     VIDEO_TIMING_GEN_LOCK_SEQ_EN defined : pll_locked is synchronized and
//       the WAIT_LOCK -> SETTLE -> RUN lock sequence is active.
//     undefined (default) : pll_locked is ignored and the FSM enters RUN on
//       the first cycle after reset; LOCK_WAIT has no effect.
module video_timing_gen #(
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 32,
  parameter int V_ACTIVE  = 224,
  parameter int V_FP      = 8,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 15,
  parameter int LOCK_WAIT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  video_timing_gen_if.master  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [7:0] V_LAST     = 8'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT_END  = 9'(H_ACTIVE);
  localparam logic [7:0] V_ACT_END  = 8'(V_ACTIVE);
  localparam logic [8:0] HS_START   = 9'(H_ACTIVE + H_FP);
  localparam logic [8:0] HS_END     = 9'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [7:0] VS_START   = 8'(V_ACTIVE + V_FP);
  localparam logic [7:0] VS_END     = 8'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   lk;        // synchronized lock (constant 1 without the lock sequence)
  logic   running;
  logic   run_en;    // RUN and lock still present this cycle

  // ---------------------------------------------------------------------
  // Lock synchronizer and settle counter
  // ---------------------------------------------------------------------
`ifdef VIDEO_TIMING_GEN_LOCK_SEQ_EN
  localparam logic [15:0] SETTLE_LAST = 16'(LOCK_WAIT - 1);

  logic        lk_meta;
  logic [15:0] settle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= vif.pll_locked;
      lk      <= lk_meta;
    end
  end

  // Counts consecutive locked cycles spent in SETTLE; any lock drop or
  // leaving SETTLE restarts it from zero.
  always_ff @(posedge clk) begin
    if (rst || state != SETTLE || !lk) begin
      settle_cnt <= 16'd0;
    end else if (settle_cnt != SETTLE_LAST) begin
      settle_cnt <= settle_cnt + 16'd1;
    end
  end
`else
  assign lk = 1'b1;

  logic unused_lock_cfg;
  assign unused_lock_cfg = vif.pll_locked ^ (LOCK_WAIT != 0);
`endif

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef VIDEO_TIMING_GEN_LOCK_SEQ_EN
      WAIT_LOCK: if (lk) state_nxt = SETTLE;
      // A lock drop wins over the count reaching its last value.
      SETTLE: begin
        if (!lk)                            state_nxt = WAIT_LOCK;
        else if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
      end
`else
      WAIT_LOCK: state_nxt = RUN;
`endif
      RUN:     if (!lk) state_nxt = WAIT_LOCK;
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    running = (state == RUN);
    // In the cycle the lock drop is seen the FSM is still in RUN, but no
    // request may be issued and the output pipeline must be flushed.
    run_en  = running && lk;
  end

  // ---------------------------------------------------------------------
  // Raster counters: cleared whenever not running so RUN entry starts at 0,0
  // ---------------------------------------------------------------------
  logic [8:0] h;
  logic [7:0] v;

  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      h <= 9'd0;
      v <= 8'd0;
    end else if (h == H_LAST) begin
      h <= 9'd0;
      v <= (v == V_LAST) ? 8'd0 : v + 8'd1;
    end else begin
      h <= h + 9'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 0 decode (counter cycle)
  // ---------------------------------------------------------------------
  logic pix_s0, hs_s0, vs_s0, fs_s0;

  always_comb begin
    pix_s0 = run_en && (h < H_ACT_END) && (v < V_ACT_END);
    hs_s0  = (h >= HS_START) && (h < HS_END);
    vs_s0  = (v >= VS_START) && (v < VS_END);
    fs_s0  = (h == 9'd0) && (v == 8'd0);
  end

  // ---------------------------------------------------------------------
  // Stages 1 and 2: {de, hsync, vsync, frame_start}. Stage 1 is the cycle
  // the source answers, so rgb is captured alongside the move to stage 2.
  // Loss of run flushes everything to zero rather than draining.
  // ---------------------------------------------------------------------
  logic [3:0]  ctl_s1, ctl_s2;
  logic [23:0] rgb_s2;

  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      ctl_s1 <= 4'd0;
      ctl_s2 <= 4'd0;
      rgb_s2 <= 24'd0;
    end else begin
      ctl_s1 <= {pix_s0, hs_s0, vs_s0, fs_s0};
      ctl_s2 <= ctl_s1;
      rgb_s2 <= ctl_s1[3] ? vif.rgb_in : 24'd0;
    end
  end

  assign vif.pixel_req   = pix_s0;
  assign vif.hcount_req  = h;
  assign vif.vcount_req  = v;
  assign vif.de          = ctl_s2[3];
  assign vif.hsync       = ctl_s2[2];
  assign vif.vsync       = ctl_s2[1];
  assign vif.frame_start = ctl_s2[0];
  assign vif.rgb_out     = rgb_s2;
  assign vif.running     = running;
  assign vif.state_dbg   = state;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Bench for video_timing_gen using a reduced raster so that several full
// frames and lock sequences fit in a short run.
module tb_video_timing_gen;

  localparam int HA = 20, HF = 4, HS = 6, HB = 5;
  localparam int VA = 10, VF = 2, VS = 3, VB = 4;
  localparam int HT = HA + HF + HS + HB;   // 35
  localparam int VT = VA + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 665
  localparam int LW = 40;

`ifdef VIDEO_TIMING_GEN_LOCK_SEQ_EN
  localparam bit LOCK_EN = 1'b1;
  localparam int LATENCY = LW + 3;  // 2 sync + 1 WAIT_LOCK->SETTLE + LW
`else
  localparam bit LOCK_EN = 1'b0;
  localparam int LATENCY = 1;
`endif
  // Consecutive locked, non-reset edges needed before running is high.
  localparam int RUN_AFTER = LOCK_EN ? LW + 1 : 1;
  localparam int OW = 28;               // {de, hs, vs, fs, rgb[23:0]}
  localparam logic [6:0] TAG = 7'h55;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  video_timing_gen_if bus();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LOCK_WAIT(LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vif (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_running(output int n, input int limit);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.running) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- pixel source: answers each request one cycle later ----
  logic       src_req = 1'b0;
  logic [8:0] src_h = '0;
  logic [7:0] src_v = '0;
  initial begin
    bus.rgb_in = '0;
    forever begin
      @(negedge clk);
      bus.rgb_in = src_req ? {TAG, src_h, src_v} : 24'($urandom);
      src_req = bus.pixel_req;
      src_h   = bus.hcount_req;
      src_v   = bus.vcount_req;
    end
  end

  // ---------------- input sampling at the active edge ----------------
  logic edge_rst = 1'b1;
  logic edge_pll = 1'b0;
  bit   edge_seen = 1'b0;
  initial forever begin
    @(posedge clk);
    edge_rst  = rst;
    edge_pll  = bus.pll_locked;
    edge_seen = 1'b1;
  end

  // ---------------- reference model + scoreboard ----------------
  // Running is a function of how many consecutive locked edges have been
  // seen; raster position is elapsed run time modulo the line/frame length.
  // Outputs are the stage-0 view two cycles earlier, zeroed by any flush.
  logic [OW-1:0] exp_q[$];
  logic [1:0]    sync_m = 2'b00;
  int            streak = 0;
  bit            model_ok = 1'b0;
  bit            mon_en = 1'b0;
  bit            running_m = 1'b0, run_en_m = 1'b0, req_m = 1'b0;
  logic [8:0]    h_m = '0;
  logic [7:0]    v_m = '0;
  logic [OW-1:0] tup_m = '0;

  initial begin
    int  t, hh, vv;
    bit  lk_now, hs_m, vs_m, fs_m;
    exp_q.push_back('0);
    exp_q.push_back('0);
    forever begin
      @(negedge clk);
      if (edge_seen) begin
        if (run_en_m && !edge_rst) begin
          exp_q.push_back(tup_m);
          void'(exp_q.pop_front());
        end else begin
          exp_q.delete();
          exp_q.push_back('0);
          exp_q.push_back('0);
        end
        if (edge_rst) begin
          sync_m   = 2'b00;
          streak   = 0;
          model_ok = 1'b1;
        end else begin
          if (!LOCK_EN || sync_m[1]) streak++;
          else streak = 0;
          sync_m = {sync_m[0], edge_pll};
        end
        running_m = (streak >= RUN_AFTER);
        lk_now    = !LOCK_EN || sync_m[1];
        run_en_m  = running_m && lk_now;
        if (running_m) begin
          t  = streak - RUN_AFTER;
          hh = t % HT;
          vv = (t / HT) % VT;
        end else begin
          hh = 0;
          vv = 0;
        end
        h_m   = 9'(hh);
        v_m   = 8'(vv);
        req_m = run_en_m && hh < HA && vv < VA;
        hs_m  = run_en_m && hh >= HA + HF && hh < HA + HF + HS;
        vs_m  = run_en_m && vv >= VA + VF && vv < VA + VF + VS;
        fs_m  = run_en_m && hh == 0 && vv == 0;
        tup_m = {req_m, hs_m, vs_m, fs_m, req_m ? {TAG, h_m, v_m} : 24'h0};
        if (model_ok && mon_en)
          check("monitor",
                64'({bus.running, bus.pixel_req, bus.hcount_req, bus.vcount_req,
                     bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rgb_out}),
                64'({running_m, req_m, h_m, v_m, exp_q[0]}));
      end
    end
  end

  // ---------------- directed vector table ----------------
  // k = cycles after running first reads high; outputs at k reflect raster
  // position t = k-2.
  typedef struct {
    int         k;
    logic       de, hs, vs, fs;
    logic [8:0] h;
    logic [7:0] v;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    int n;
    int vi;
    int de_cnt;
    int fs_k[$];
    bit found;

    vecs[0]  = '{0,   0, 0, 0, 0, 9'd0,  8'd0};
    vecs[1]  = '{1,   0, 0, 0, 0, 9'd0,  8'd0};
    vecs[2]  = '{2,   1, 0, 0, 1, 9'd0,  8'd0};
    vecs[3]  = '{3,   1, 0, 0, 0, 9'd1,  8'd0};
    vecs[4]  = '{21,  1, 0, 0, 0, 9'd19, 8'd0};
    vecs[5]  = '{22,  0, 0, 0, 0, 9'd0,  8'd0};
    vecs[6]  = '{25,  0, 0, 0, 0, 9'd0,  8'd0};
    vecs[7]  = '{26,  0, 1, 0, 0, 9'd0,  8'd0};
    vecs[8]  = '{31,  0, 1, 0, 0, 9'd0,  8'd0};
    vecs[9]  = '{32,  0, 0, 0, 0, 9'd0,  8'd0};
    vecs[10] = '{37,  1, 0, 0, 0, 9'd0,  8'd1};
    vecs[11] = '{336, 1, 0, 0, 0, 9'd19, 8'd9};
    vecs[12] = '{352, 0, 0, 0, 0, 9'd0,  8'd0};
    vecs[13] = '{421, 0, 0, 0, 0, 9'd0,  8'd0};
    vecs[14] = '{422, 0, 0, 1, 0, 9'd0,  8'd0};
    vecs[15] = '{526, 0, 0, 1, 0, 9'd0,  8'd0};
    vecs[16] = '{527, 0, 0, 0, 0, 9'd0,  8'd0};
    vecs[17] = '{667, 1, 0, 0, 1, 9'd0,  8'd0};

    // Reset with the lock already present (tied low when lock is ignored).
    bus.pll_locked = LOCK_EN;
    rst = 1'b1;
    tick(3);
    mon_en = 1'b1;
    check("reset_outputs",
          64'({bus.running, bus.pixel_req, bus.hcount_req, bus.vcount_req,
               bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rgb_out}),
          64'(0));
    rst = 1'b0;
    wait_running(n, LATENCY + 50);
    check("lock_latency", 64'(n), 64'(LATENCY));

    // Two frames: table vectors plus per-frame de and frame_start spacing.
    vi = 0;
    de_cnt = 0;
    for (int k = 0; k <= 2 * FRAME + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.de && k < 2 * FRAME + 2) de_cnt++;
      if (bus.frame_start) fs_k.push_back(k);
      while (vi < NV && vecs[vi].k == k) begin
        check($sformatf("vec%0d", vi),
              64'({bus.de, bus.hsync, bus.vsync, bus.frame_start, bus.rgb_out}),
              64'({vecs[vi].de, vecs[vi].hs, vecs[vi].vs, vecs[vi].fs,
                   vecs[vi].de ? {TAG, vecs[vi].h, vecs[vi].v} : 24'h0}));
        vi++;
      end
    end
    check("de_per_two_frames", 64'(de_cnt), 64'(2 * HA * VA));
    check("frame_start_count", 64'(fs_k.size()), 64'(3));
    if (fs_k.size() == 3) begin
      check("frame_start_first", 64'(fs_k[0]), 64'(2));
      check("frame_period_1", 64'(fs_k[1] - fs_k[0]), 64'(FRAME));
      check("frame_period_2", 64'(fs_k[2] - fs_k[1]), 64'(FRAME));
    end

`ifdef VIDEO_TIMING_GEN_LOCK_SEQ_EN
    // Drop lock mid-line on line 5.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.hcount_req == 9'd10 && bus.vcount_req == 8'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_line5", 64'(found), 64'(1));
    bus.pll_locked = 1'b0;
    tick(3);
    check("drop_flush",
          64'({bus.running, bus.de, bus.hsync, bus.vsync, bus.rgb_out}), 64'(0));
    tick(5);
    bus.pll_locked = 1'b1;
    wait_running(n, LATENCY + 50);
    check("relock_latency", 64'(n), 64'(LATENCY));
    check("restart_coords",
          64'({bus.pixel_req, bus.hcount_req, bus.vcount_req}), 64'({1'b1, 9'd0, 8'd0}));
    tick(2);
    check("restart_frame_start", 64'(bus.frame_start), 64'(1));

    // Lock glitch during SETTLE at roughly count 20.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3 + 20);
    bus.pll_locked = 1'b0;
    tick(5);
    bus.pll_locked = 1'b1;
    wait_running(n, LATENCY + 50);
    check("glitch_relock_latency", 64'(n), 64'(LATENCY));
`else
    // Lock is ignored: toggling it must not disturb RUN.
    bus.pll_locked = 1'b1;
    tick(2);
    bus.pll_locked = 1'b0;
    tick(5);
    check("lock_ignored", 64'(bus.running), 64'(1));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_running(n, 20);
    check("rerun_latency", 64'(n), 64'(1));
    tick(2);
    check("rerun_frame_start", 64'(bus.frame_start), 64'(1));
`endif

    // Randomized lock drops and mid-frame resets, checked by the model.
    for (int it = 0; it < 24; it++) begin
      tick(int'($urandom_range(200, 20)));
      if ($urandom_range(3, 0) == 0) begin
        rst = 1'b1;
        tick(int'($urandom_range(3, 1)));
        rst = 1'b0;
      end else begin
        bus.pll_locked = 1'b0;
        tick(int'($urandom_range(8, 1)));
        bus.pll_locked = 1'b1;
      end
    end
    tick(LW + 2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
